// File: rtl/tsn_slot_timebase.sv
// TSN test NIC slot/timestamp engine: GCL slot sequencing, prefetch reads,
// period config shadowing and run/hold/done test window control.
`timescale 1ns / 1ps
module tsn_slot_timebase #(
    parameter int TS_W     = 48,
    parameter int CYC_W    = 20,
    parameter int SID_W    = 9,
    parameter int GRP_W    = 4,
    parameter int PREFETCH = 3,
    parameter int HOLD_CYC = 125_000_100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CYC_W-1:0]       cfg_slot_cyc,
    input  logic [SID_W:0]         cfg_num_slots,
    input  logic                   cfg_wr,
    input  logic                   test_start,
    input  logic                   test_stop,
    output logic                   slot_shift,
    output logic                   slot_pulse,
    output logic [SID_W-1:0]       slot_id,
    output logic [GRP_W-1:0]       grp_idx,
    output logic                   gcl_rd,
    output logic [SID_W-GRP_W-1:0] gcl_addr,
    output logic [31:0]            period_cnt,
    output logic [TS_W-1:0]        timestamp,
    output logic                   cnt_rst,
    output logic [1:0]             state
);

    localparam int HC_W = $clog2(HOLD_CYC + 1);

    localparam logic [CYC_W-1:0] MIN_CYC   = CYC_W'(PREFETCH + 1);
    localparam logic [CYC_W-1:0] LEAD      = CYC_W'(PREFETCH);
    localparam logic [CYC_W-1:0] ONE_C     = CYC_W'(1);
    localparam logic [SID_W:0]   MAX_SLOTS = {1'b1, {SID_W{1'b0}}};
    localparam logic [SID_W:0]   ONE_N     = {{SID_W{1'b0}}, 1'b1};
    localparam logic [SID_W-1:0] ONE_S     = {{(SID_W-1){1'b0}}, 1'b1};
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);
    localparam logic [HC_W-1:0]  ONE_H     = HC_W'(1);
    localparam logic [TS_W-1:0]  ONE_T     = TS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t st_q, st_d;

    logic [CYC_W-1:0] act_cyc_q, act_cyc_d;
    logic [SID_W:0]   act_num_q, act_num_d;
    logic             pend_q, pend_d;
    logic [CYC_W-1:0] pend_cyc_q, pend_cyc_d;
    logic [SID_W:0]   pend_num_q, pend_num_d;

    logic [CYC_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [SID_W-1:0] slot_id_d;
    logic             shift_d;
    logic             pulse_d;
    logic [31:0]      period_d;

    logic                   rd_d;
    logic [SID_W-GRP_W-1:0] addr_d;
    logic [SID_W-1:0]       nid;
    logic                   last_sid_d;

    logic [HC_W-1:0] hold_q, hold_d;
    logic [TS_W-1:0] ts_d;
    logic            cnt_rst_d;

    logic [CYC_W-1:0] cyc_in;
    logic [SID_W:0]   num_in;
    logic             in_run, last_cyc, last_sid;
    logic             wrap, idle_entry, apply;

    assign state   = st_q;
    assign grp_idx = slot_id[GRP_W-1:0];

    // Out-of-range config is clamped once, at capture time.
    assign cyc_in = (cfg_slot_cyc < MIN_CYC) ? MIN_CYC : cfg_slot_cyc;
    assign num_in = (cfg_num_slots == '0 || cfg_num_slots > MAX_SLOTS)
                  ? MAX_SLOTS : cfg_num_slots;

    assign in_run     = (st_q == S_RUN) && (st_d == S_RUN);
    assign last_cyc   = slot_cnt_q >= (act_cyc_q - ONE_C);
    assign last_sid   = {1'b0, slot_id} == (act_num_q - ONE_N);
    assign wrap       = in_run && last_cyc && last_sid;
    assign idle_entry = (st_d == S_IDLE) && (st_q != S_IDLE);
    assign apply      = wrap || idle_entry;

    always_comb begin : fsm_next
        st_d = st_q;
        unique case (st_q)
            S_IDLE: if (test_start) st_d = S_RUN;
            S_RUN: begin
                if (!test_start) st_d = test_stop ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (test_start)              st_d = S_RUN;
                else if (hold_q == HOLD_LAST) st_d = S_DONE;
            end
            S_DONE: begin
                if (test_start)      st_d = S_RUN;
                else if (!test_stop) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_comb begin : fsm_out
        cnt_rst_d = (st_d == S_IDLE) || (st_d == S_DONE);
        ts_d      = (st_d == S_IDLE || st_q == S_IDLE) ? '0 : timestamp + ONE_T;
        hold_d    = hold_q;
        if (st_q == S_HOLD && st_d == S_HOLD)
            hold_d = hold_q + ONE_H;
        else if (st_d == S_RUN || st_d == S_IDLE)
            hold_d = '0;
    end

    // A write landing on the apply cycle itself takes effect immediately.
    always_comb begin : cfg_next
        act_cyc_d  = act_cyc_q;
        act_num_d  = act_num_q;
        pend_d     = pend_q;
        pend_cyc_d = pend_cyc_q;
        pend_num_d = pend_num_q;
        if (apply && (cfg_wr || pend_q)) begin
            act_cyc_d = cfg_wr ? cyc_in : pend_cyc_q;
            act_num_d = cfg_wr ? num_in : pend_num_q;
            pend_d    = 1'b0;
        end else if (cfg_wr) begin
            if (st_q == S_IDLE) begin
                act_cyc_d = cyc_in;
                act_num_d = num_in;
            end else begin
                pend_cyc_d = cyc_in;
                pend_num_d = num_in;
                pend_d     = 1'b1;
            end
        end
    end

    always_comb begin : slot_next
        slot_cnt_d = slot_cnt_q;
        slot_id_d  = slot_id;
        shift_d    = slot_shift;
        period_d   = period_cnt;
        pulse_d    = 1'b0;
        if (st_d != S_RUN) begin
            slot_cnt_d = '0;
            slot_id_d  = '0;
            shift_d    = 1'b0;
            period_d   = '0;
        end else if (st_q == S_RUN) begin
            if (last_cyc) begin
                slot_cnt_d = '0;
                shift_d    = ~slot_shift;
                pulse_d    = 1'b1;
                if (last_sid) begin
                    slot_id_d = '0;
                    period_d  = period_cnt + 32'd1;
                end else begin
                    slot_id_d = slot_id + ONE_S;
                end
            end else begin
                slot_cnt_d = slot_cnt_q + ONE_C;
            end
        end
    end

    // Prefetch strobe is aligned to the registered slot_cnt/slot_id values.
    always_comb begin : gcl_next
        last_sid_d = {1'b0, slot_id_d} == (act_num_d - ONE_N);
        nid        = last_sid_d ? '0 : slot_id_d + ONE_S;
        rd_d       = (st_d == S_RUN)
                   && (slot_cnt_d == act_cyc_d - ONE_C - LEAD)
                   && ((&slot_id_d[GRP_W-1:0]) || last_sid_d);
        addr_d     = gcl_addr;
        if (st_d != S_RUN)
            addr_d = '0;
        else if (rd_d)
            addr_d = nid[SID_W-1:GRP_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= S_IDLE;
            act_cyc_q  <= MIN_CYC;
            act_num_q  <= MAX_SLOTS;
            pend_q     <= 1'b0;
            pend_cyc_q <= '0;
            pend_num_q <= '0;
            slot_cnt_q <= '0;
            slot_id    <= '0;
            slot_shift <= 1'b0;
            slot_pulse <= 1'b0;
            period_cnt <= '0;
            gcl_rd     <= 1'b0;
            gcl_addr   <= '0;
            hold_q     <= '0;
            timestamp  <= '0;
            cnt_rst    <= 1'b1;
        end else begin
            st_q       <= st_d;
            act_cyc_q  <= act_cyc_d;
            act_num_q  <= act_num_d;
            pend_q     <= pend_d;
            pend_cyc_q <= pend_cyc_d;
            pend_num_q <= pend_num_d;
            slot_cnt_q <= slot_cnt_d;
            slot_id    <= slot_id_d;
            slot_shift <= shift_d;
            slot_pulse <= pulse_d;
            period_cnt <= period_d;
            gcl_rd     <= rd_d;
            gcl_addr   <= addr_d;
            hold_q     <= hold_d;
            timestamp  <= ts_d;
            cnt_rst    <= cnt_rst_d;
        end
    end

endmodule

// File: tb/tb_tsn_slot_timebase.sv
// Bench for tsn_slot_timebase: FSM vector table plus slot/prefetch
// event scoreboard over several run scenarios.
`timescale 1ns / 1ps
module tb_tsn_slot_timebase;

    localparam int TS_W  = 48;
    localparam int CYC_W = 20;
    localparam int SID_W = 9;
    localparam int GRP_W = 4;
    localparam int GRP_N = 16;
    localparam int LEADC = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [CYC_W-1:0]       cfg_slot_cyc = '0;
    logic [SID_W:0]         cfg_num_slots = '0;
    logic                   cfg_wr = 1'b0;
    logic                   test_start = 1'b0;
    logic                   test_stop = 1'b0;
    logic                   slot_shift, slot_pulse, gcl_rd, cnt_rst;
    logic [SID_W-1:0]       slot_id;
    logic [GRP_W-1:0]       grp_idx;
    logic [SID_W-GRP_W-1:0] gcl_addr;
    logic [31:0]            period_cnt;
    logic [TS_W-1:0]        timestamp;
    logic [1:0]             state;

    tsn_slot_timebase #(.HOLD_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_slot_cyc(cfg_slot_cyc), .cfg_num_slots(cfg_num_slots),
        .cfg_wr(cfg_wr), .test_start(test_start), .test_stop(test_stop),
        .slot_shift(slot_shift), .slot_pulse(slot_pulse),
        .slot_id(slot_id), .grp_idx(grp_idx),
        .gcl_rd(gcl_rd), .gcl_addr(gcl_addr),
        .period_cnt(period_cnt), .timestamp(timestamp),
        .cnt_rst(cnt_rst), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cyc;
        int     sid;
        int     per;
        bit     sh;
    } pulse_t;

    typedef struct {
        longint cyc;
        int     addr;
    } gcl_t;

    typedef struct {
        bit wr;
        int cyc;
        int num;
        bit start;
        bit stop;
        int st;
        bit crst;
        int ts;
    } vec_t;

    pulse_t pq[$];
    gcl_t   gq[$];
    vec_t   vt[13];
    int     checks = 0;
    int     errors = 0;
    longint cyc_no = 0;
    bit     mon_en = 1'b0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                     name, act, exp, cyc_no);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input longint t);
        while (cyc_no < t) tick();
    endtask

    task automatic start_run(output longint c0);
        test_start = 1'b1;
        tick();
        c0 = cyc_no;
    endtask

    // Expected slot events: period 0 uses (ca,na), later periods (cb,nb).
    task automatic plan(input longint c0, input longint t_end,
                        input int ca, input int na,
                        input int cb, input int nb);
        longint t = c0;
        int s = 0, p = 0, cyc = ca, num = na;
        bit sh = 1'b0;
        pulse_t pe;
        gcl_t ge;
        for (int g = 0; g < 100000; g++) begin
            if ((s % GRP_N == GRP_N - 1 || s == num - 1)
                && t + cyc - LEADC <= t_end) begin
                ge.cyc  = t + cyc - LEADC;
                ge.addr = ((s == num - 1) ? 0 : s + 1) / GRP_N;
                gq.push_back(ge);
            end
            if (t + cyc > t_end) break;
            t  = t + cyc;
            sh = !sh;
            if (s == num - 1) begin
                s = 0;
                p++;
                cyc = cb;
                num = nb;
            end else begin
                s++;
            end
            pe = '{t, s, p, sh};
            pq.push_back(pe);
        end
    endtask

    always @(negedge clk) begin
        pulse_t pe;
        gcl_t ge;
        if (rst_n && gcl_rd) chk("gcl_rd_only_in_run", state, 1);
        if (rst_n && mon_en && slot_pulse) begin
            if (pq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse: got slot_pulse at cycle %0d, required none",
                         cyc_no);
            end else begin
                pe = pq.pop_front();
                chk("pulse_cycle", cyc_no, pe.cyc);
                chk("pulse_slot_id", slot_id, pe.sid);
                chk("pulse_grp_idx", grp_idx, pe.sid % GRP_N);
                chk("pulse_period", period_cnt, pe.per);
                chk("pulse_shift", slot_shift, pe.sh);
            end
        end
        if (rst_n && mon_en && gcl_rd) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gcl_rd: got strobe at cycle %0d, required none",
                         cyc_no);
            end else begin
                ge = gq.pop_front();
                chk("gcl_cycle", cyc_no, ge.cyc);
                chk("gcl_addr", gcl_addr, ge.addr);
            end
        end
    end

    task automatic end_phase(input string name);
        chk({name, "_pulses_left"}, pq.size(), 0);
        chk({name, "_gcl_left"}, gq.size(), 0);
        pq.delete();
        gq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        int hold_seen;

        //        wr cyc num st sp  state crst ts
        vt[0]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        vt[1]  = '{0, 0, 0, 1, 0, 1, 0, 0};
        vt[2]  = '{0, 0, 0, 1, 0, 1, 0, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        vt[4]  = '{0, 0, 0, 1, 0, 1, 0, 0};
        vt[5]  = '{0, 0, 0, 0, 1, 2, 0, 1};
        vt[6]  = '{0, 0, 0, 1, 1, 1, 0, 2};
        vt[7]  = '{0, 0, 0, 0, 1, 2, 0, 3};
        vt[8]  = '{0, 0, 0, 0, 0, 2, 0, 4};
        vt[9]  = '{0, 0, 0, 1, 0, 1, 0, 5};
        vt[10] = '{0, 0, 0, 0, 0, 0, 1, 0};
        vt[11] = '{1, 1, 0, 0, 0, 0, 1, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 1, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_cnt_rst", cnt_rst, 1);
        chk("rst_timestamp", timestamp, 0);
        chk("rst_slot_id", slot_id, 0);
        chk("rst_slot_shift", slot_shift, 0);
        chk("rst_slot_pulse", slot_pulse, 0);
        chk("rst_gcl_rd", gcl_rd, 0);
        chk("rst_gcl_addr", gcl_addr, 0);
        chk("rst_period", period_cnt, 0);
        rst_n = 1'b1;

        // FSM transition table
        for (int i = 0; i < 13; i++) begin
            cfg_wr        = vt[i].wr;
            cfg_slot_cyc  = vt[i].cyc[CYC_W-1:0];
            cfg_num_slots = vt[i].num[SID_W:0];
            test_start    = vt[i].start;
            test_stop     = vt[i].stop;
            tick();
            chk($sformatf("vec%0d_state", i), state, vt[i].st);
            chk($sformatf("vec%0d_cnt_rst", i), cnt_rst, vt[i].crst);
            chk($sformatf("vec%0d_ts", i), timestamp, vt[i].ts);
        end
        cfg_wr = 1'b0;

        // Clamped config (cyc=1 -> 4, slots=0 -> 512): full period
        mon_en = 1'b1;
        start_run(c0);
        plan(c0, c0 + 2056, 4, 512, 4, 512);
        run_until(c0 + 2056);
        test_start = 1'b0;
        tick();
        chk("clamp_idle_state", state, 0);
        chk("clamp_idle_cnt_rst", cnt_rst, 1);
        chk("clamp_idle_period", period_cnt, 0);
        end_phase("clamp");

        // cyc=10, 32 slots, cfg_wr together with start
        cfg_slot_cyc  = 20'd10;
        cfg_num_slots = 10'd32;
        cfg_wr        = 1'b1;
        start_run(c0);
        cfg_wr = 1'b0;
        plan(c0, c0 + 325, 10, 32, 10, 32);
        run_until(c0 + 320);
        chk("t1_period_after_320", period_cnt, 1);
        chk("t1_slot_id_after_320", slot_id, 0);
        run_until(c0 + 325);
        chk("t1_timestamp", timestamp, 325);
        test_start = 1'b0;
        tick();
        chk("t1_idle_ts", timestamp, 0);
        end_phase("t1");

        // Shadowed config: two writes mid-period, second wins at wrap
        start_run(c0);
        plan(c0, c0 + 385, 10, 32, 20, 32);
        run_until(c0 + 52);
        cfg_slot_cyc = 20'd30;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        run_until(c0 + 72);
        cfg_slot_cyc = 20'd20;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        run_until(c0 + 385);
        test_start = 1'b0;
        tick();
        end_phase("t3");

        // HOLD window of 100 cycles, then DONE, then IDLE
        mon_en = 1'b0;
        start_run(c0);
        repeat (4) tick();
        test_start = 1'b0;
        test_stop  = 1'b1;
        tick();
        chk("t4_hold_state", state, 2);
        chk("t4_hold_ts", timestamp, 5);
        chk("t4_hold_slot_id", slot_id, 0);
        hold_seen = (cnt_rst == 1'b0 && state == 2'd2) ? 1 : 0;
        repeat (99) begin
            tick();
            if (cnt_rst == 1'b0 && state == 2'd2) hold_seen++;
        end
        chk("t4_hold_cycles", hold_seen, 100);
        tick();
        chk("t4_done_state", state, 3);
        chk("t4_done_cnt_rst", cnt_rst, 1);
        chk("t4_done_ts", timestamp, 105);
        repeat (3) tick();
        chk("t4_done_ts_runs", timestamp, 108);
        test_stop = 1'b0;
        tick();
        chk("t4_idle_state", state, 0);
        chk("t4_idle_ts", timestamp, 0);
        chk("t4_idle_cnt_rst", cnt_rst, 1);

        // Async reset mid-run with a pending config
        cfg_slot_cyc  = 20'd10;
        cfg_num_slots = 10'd32;
        cfg_wr        = 1'b1;
        tick();
        cfg_wr = 1'b0;
        start_run(c0);
        run_until(c0 + 72);
        cfg_slot_cyc = 20'd40;
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        run_until(c0 + 75);
        chk("t6_pre_slot_id", slot_id, 7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_cnt_rst", cnt_rst, 1);
        chk("t6_rst_slot_id", slot_id, 0);
        chk("t6_rst_ts", timestamp, 0);
        chk("t6_rst_shift", slot_shift, 0);
        test_start = 1'b0;
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start_run(c0);
            plan(c0, c0 + 40, 4, 512, 4, 512);
            run_until(c0 + 40);
            test_start = 1'b0;
            tick();
            end_phase($sformatf("t6_run%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
